ext_stage: RTL and testbench

Parametrised, pipelined immediate-extension stage for the pipelined CPU. It takes an immediate field plus an extension mode from decode and produces a full-width operand with a tag, one cycle later. A two-entry skid buffer with valid/ready handshakes on both sides lets the stage absorb downstream stalls at full throughput. It sits between decode and the ID/EX boundary, and supports zero, sign, upper-load and branch-offset extension.

---
 rtl/ext_pkg.sv | 18 +
 rtl/ext_stage_if.sv | 33 +++
 rtl/ext_core.sv | 34 +++
 rtl/ext_stage.sv | 111 +++++++++++
 tb/tb_ext_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ext_pkg.sv
// Shared constants for the immediate-extension stage.
//   - EXT_* : 2-bit extension mode encodings presented on in_mode
//   - ext_state_t : occupancy of the two-entry skid buffer
package ext_pkg;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] EXT_SHL2  = 2'b11;

    // EMPTY: nothing held; ONE: output register full; TWO: output + skid full
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ext_state_t;

endpackage

// File: rtl/ext_stage_if.sv
// Handshake bundle for ext_stage.
//   producer side : flush, in_valid, in_mode, in_imm, in_tag -> stage; in_ready <- stage
//   consumer side : out_ready -> stage; out_valid, out_data, out_tag <- stage
//   master modport: the environment driving decode and consuming results
//   slave modport : the extension stage itself
interface ext_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 32
) ();

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [IN_W-1:0]   in_imm;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output flush, in_valid, in_mode, in_imm, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  flush, in_valid, in_mode, in_imm, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/ext_core.sv
// Purely combinational immediate extender.
//   mode : extension mode (EXT_ZERO / EXT_SIGN / EXT_UPPER / EXT_SHL2)
//   imm  : IN_W-bit immediate field
//   ext  : OUT_W-bit extended operand (OUT_W must be >= IN_W+2)
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] ext
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{PAD_W{imm[IN_W-1]}}, imm};

    always_comb begin
        ext = '0;
        case (mode)
            EXT_ZERO:  ext = {{PAD_W{1'b0}}, imm};
            EXT_SIGN:  ext = sext;
            EXT_UPPER: ext = {imm, {PAD_W{1'b0}}};
            // top two sign copies fall off the end; low two bits become zero
            EXT_SHL2:  ext = {sext[OUT_W-3:0], 2'b00};
            default:   ext = '0;
        endcase
    end

endmodule

// File: rtl/ext_stage.sv
// Pipelined immediate-extension stage with a two-entry skid buffer.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ext_stage_if.slave - input handshake (in_*), output handshake
//           (out_*), and synchronous flush
// The extender sits on the input path so both storage slots hold finished
// operands. in_ready and out_valid are flops computed from the next state,
// so neither depends combinationally on the consumer's out_ready.
module ext_stage
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    ext_stage_if.slave    bus
);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } item_t;

    ext_state_t state_q, state_d;
    item_t      or_q, or_d;          // output register
    item_t      sk_q, sk_d;          // skid register
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;

    logic [OUT_W-1:0] ext_data;
    item_t            in_item;
    logic             acc;
    logic             take;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode (bus.in_mode),
        .imm  (bus.in_imm),
        .ext  (ext_data)
    );

    assign in_item = '{data: ext_data, tag: bus.in_tag};

    // A flushed cycle never captures its input; its output transfer still counts.
    assign acc  = bus.in_valid & in_ready_q & ~bus.flush;
    assign take = out_valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    or_d    = in_item;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && take) begin
                    or_d = in_item;
                end else if (acc) begin
                    sk_d    = in_item;
                    state_d = ST_TWO;
                end else if (take) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only draining is possible
                if (take) begin
                    or_d    = sk_q;
                    sk_d    = '0;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            or_q        <= '0;
            sk_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            or_q        <= or_d;
            sk_q        <= sk_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = or_q.data;
    assign bus.out_tag   = or_q.tag;

endmodule

// File: tb/tb_ext_stage.sv
// Directed + reference-queue testbench for ext_stage (IN_W=16, OUT_W=32).
// Inputs are driven and outputs sampled on the falling edge.
module tb_ext_stage;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ext_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(32)) bif ();

    ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] i);
        case (m)
            2'b00:   return {16'h0000, i};
            2'b01:   return {{16{i[15]}}, i};
            2'b10:   return {i, 16'h0000};
            default: return {{14{i[15]}}, i, 2'b00};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm,
                         input logic [31:0] tag);
        bif.in_valid = v;
        bif.in_mode  = m;
        bif.in_imm   = imm;
        bif.in_tag   = tag;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t mv[5];
    logic [31:0] q_data[$];
    logic [31:0] q_tag[$];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bif.flush     = 1'b0;
        bif.out_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 32'h0);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_in_ready",  bif.in_ready,  1);
        chk("rst_out_data",  bif.out_data,  0);
        chk("rst_out_tag",   bif.out_tag,   0);
        reset = 1'b1;
        cyc();

        // mode checks, one cycle latency each
        mv[0] = '{2'b00, 16'h8001, 32'h00008001};
        mv[1] = '{2'b01, 16'h8001, 32'hFFFF8001};
        mv[2] = '{2'b10, 16'h1234, 32'h12340000};
        mv[3] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
        mv[4] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
        bif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mv[i].m, mv[i].imm, 32'h100 + i);
            cyc();
            chk("mode_valid", bif.out_valid, 1);
            chk("mode_data",  bif.out_data,  mv[i].exp);
            chk("mode_tag",   bif.out_tag,   32'h100 + i);
        end
        drive(1'b0, 2'b00, 16'h0, 32'h0);
        cyc();
        chk("mode_drain", bif.out_valid, 0);

        // streaming, 8 back-to-back items
        for (int i = 0; i < 8; i++) begin
            chk("strm_in_ready", bif.in_ready, 1);
            drive(1'b1, 2'b00, 16'(i * 16'h0111), i);
            cyc();
            chk("strm_valid", bif.out_valid, 1);
            chk("strm_tag",   bif.out_tag,   i);
            chk("strm_data",  bif.out_data,  32'(i * 32'h0111));
        end
        drive(1'b0, 2'b00, 16'h0, 32'h0);
        cyc();
        chk("strm_drain", bif.out_valid, 0);

        // backpressure: A, B fill both slots, C waits
        bif.out_ready = 1'b0;
        drive(1'b1, 2'b01, 16'hAAAA, 32'hA);
        cyc();
        chk("bp_a_ready", bif.in_ready, 1);
        chk("bp_a_data",  bif.out_data, 32'hFFFFAAAA);
        drive(1'b1, 2'b00, 16'hBBBB, 32'hB);
        cyc();
        chk("bp_b_ready", bif.in_ready, 0);
        chk("bp_b_data",  bif.out_data, 32'hFFFFAAAA);
        drive(1'b1, 2'b10, 16'hCCCC, 32'hC);
        cyc();
        chk("bp_hold_ready", bif.in_ready, 0);
        chk("bp_hold_data",  bif.out_data, 32'hFFFFAAAA);
        chk("bp_hold_tag",   bif.out_tag,  32'hA);
        bif.out_ready = 1'b1;
        cyc();
        chk("bp_b_out",   bif.out_tag,  32'hB);
        chk("bp_b_odata", bif.out_data, 32'h0000BBBB);
        chk("bp_reready", bif.in_ready, 1);
        cyc();
        chk("bp_c_out",   bif.out_tag,  32'hC);
        chk("bp_c_odata", bif.out_data, 32'hCCCC0000);
        drive(1'b0, 2'b00, 16'h0, 32'h0);
        cyc();
        chk("bp_no_dup", bif.out_valid, 0);

        // flush in TWO with an input presented
        bif.out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h1111, 32'h51);
        cyc();
        drive(1'b1, 2'b00, 16'h2222, 32'h52);
        cyc();
        chk("fl_two", bif.in_ready, 0);
        drive(1'b1, 2'b00, 16'h3333, 32'h53);
        bif.flush = 1'b1;
        cyc();
        bif.flush = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 32'h0);
        chk("fl_valid", bif.out_valid, 0);
        chk("fl_ready", bif.in_ready,  1);
        bif.out_ready = 1'b1;
        cyc();
        chk("fl_stays_empty", bif.out_valid, 0);

        // random traffic vs reference queue
        for (int n = 0; n < 10000; n++) begin
            logic        v, r;
            logic [1:0]  m;
            logic [15:0] imm;
            logic [31:0] tag;
            chk("rnd_in_ready",  bif.in_ready,  q_data.size() < 2);
            chk("rnd_out_valid", bif.out_valid, q_data.size() > 0);
            v   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            m   = 2'($urandom_range(0, 3));
            imm = 16'($urandom);
            tag = $urandom;
            drive(v, m, imm, tag);
            bif.out_ready = r;
            if (r && q_data.size() > 0) begin
                chk("rnd_data", bif.out_data, q_data[0]);
                chk("rnd_tag",  bif.out_tag,  q_tag[0]);
                void'(q_data.pop_front());
                void'(q_tag.pop_front());
            end
            if (v && q_data.size() + ((r && bif.out_valid) ? 1 : 0) < 2) begin
                q_data.push_back(ref_ext(m, imm));
                q_tag.push_back(tag);
            end
            if (q_data.size() > 2) begin
                chk("rnd_inflight", q_data.size(), 2);
            end
            cyc();
        end
        drive(1'b0, 2'b00, 16'h0, 32'h0);
        bif.out_ready = 1'b1;
        repeat (3) cyc();
        q_data.delete();
        q_tag.delete();

        // async reset mid-stall
        bif.out_ready = 1'b0;
        drive(1'b1, 2'b01, 16'h9999, 32'h71);
        cyc();
        drive(1'b1, 2'b01, 16'h8888, 32'h72);
        cyc();
        drive(1'b0, 2'b00, 16'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", bif.out_valid, 0);
        chk("ar_data",  bif.out_data,  0);
        chk("ar_tag",   bif.out_tag,   0);
        chk("ar_ready", bif.in_ready,  1);
        @(negedge clk);
        reset = 1'b1;
        bif.out_ready = 1'b1;
        drive(1'b1, 2'b11, 16'h0001, 32'h73);
        cyc();
        chk("ar_post_valid", bif.out_valid, 1);
        chk("ar_post_data",  bif.out_data,  32'h00000004);
        chk("ar_post_tag",   bif.out_tag,   32'h73);
        drive(1'b0, 2'b00, 16'h0, 32'h0);
        cyc();
        chk("ar_post_drain", bif.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
